// File: rtl/mimo_drain_arbiter_pkg.sv
// mimo_pkg: shared branch count, branch index type and arbiter state encoding.
package mimo_pkg;
  localparam int NUM_BRANCHES = 8;
  typedef logic [2:0] branch_t;
  typedef enum logic {IDLE, HOLD} arb_state_t;
endpackage

// File: rtl/mimo_drain_arbiter_if.sv
// mimo_drain_arbiter_if: branch inputs, pop strobes and merged output handshake.
interface mimo_drain_arbiter_if #(parameter int WIDTH = 16) ();
  logic [8*WIDTH-1:0] i_data;
  logic [7:0] i_valid;
  logic [7:0] o_ready;
  logic [WIDTH-1:0] o_data;
  logic [2:0] o_branch;
  logic o_valid;
  logic i_ready;
  logic o_busy;
  modport slave(input i_data, i_valid, i_ready, output o_ready, o_data, o_branch, o_valid, o_busy);
  modport master(output i_data, i_valid, i_ready, input o_ready, o_data, o_branch, o_valid, o_busy);
endinterface

// File: rtl/mimo_drain_arbiter_rr_priority_pick.sv
// rr_priority_pick: first set request at or after start, searching upward with wrap.
module rr_priority_pick
  import mimo_pkg::*;
(
  input  logic [7:0] req,
  input  branch_t    start,
  output logic       found,
  output branch_t    idx
);
  always_comb begin
    found = 1'b0;
    idx = start;
    for (int i = NUM_BRANCHES - 1; i >= 0; i--)
      if (req[start + 3'(i)]) begin
        found = 1'b1;
        idx = start + 3'(i);
      end
  end
endmodule

// File: rtl/mimo_drain_arbiter.sv
// mimo_drain_arbiter: 8-to-1 round-robin burst arbiter draining into one registered output.
// Define MIMO_DRAIN_ARB_STATS_EN to add per-branch saturating grant counters on o_grant_count.
module mimo_drain_arbiter
  import mimo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BURST = 4
) (
  input logic i_clock,
  input logic i_reset,
  mimo_drain_arbiter_if.slave bus
`ifdef MIMO_DRAIN_ARB_STATS_EN
  , output logic [8*16-1:0] o_grant_count
`endif
);
  arb_state_t state, state_n;
  branch_t g, g_n, p, p_n, sp, idx, gnt;
  logic [3:0] c, c_n;
  logic found, others, rel, hold, can_load, pop, burst_done;
  rr_priority_pick u_pick(.req(bus.i_valid), .start(sp), .found(found), .idx(idx));
  always_comb begin
    burst_done = c == 4'(BURST);
    others = |(bus.i_valid & ~(8'b1 << g));
    rel = state == HOLD && (!bus.i_valid[g] || (burst_done && others));
    hold = state == HOLD && !rel;
    sp = state == HOLD ? g + 3'd1 : p;
    gnt = hold ? g : idx;
    can_load = !bus.o_valid || bus.i_ready;
    pop = !i_reset && can_load && (hold || found);
    bus.o_ready = pop ? 8'b1 << gnt : 8'b0;
    state_n = (hold || found) ? HOLD : IDLE;
    g_n = gnt;
    // a sole requester at the burst limit restarts its count on the next beat
    c_n = hold ? (pop ? (burst_done ? 4'd1 : c + 4'd1) : c) : {3'b0, pop};
    p_n = rel ? g + 3'd1 : p;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      g <= '0;
      c <= '0;
      p <= '0;
      bus.o_valid <= 1'b0;
      bus.o_data <= '0;
      bus.o_branch <= '0;
    end else begin
      state <= state_n;
      g <= g_n;
      c <= c_n;
      p <= p_n;
      if (pop) begin
        bus.o_data <= bus.i_data[gnt*WIDTH +: WIDTH];
        bus.o_branch <= gnt;
        bus.o_valid <= 1'b1;
      end else if (bus.i_ready) bus.o_valid <= 1'b0;
    end
  end
  assign bus.o_busy = bus.o_valid || |bus.i_valid;
`ifdef MIMO_DRAIN_ARB_STATS_EN
  logic [15:0] cnt [NUM_BRANCHES];
  always_ff @(posedge i_clock)
    for (int n = 0; n < NUM_BRANCHES; n++)
      if (i_reset) cnt[n] <= '0;
      else if (bus.o_ready[n] && bus.i_valid[n] && cnt[n] != 16'hFFFF) cnt[n] <= cnt[n] + 16'd1;
  for (genvar n = 0; n < NUM_BRANCHES; n++) begin : g_cnt
    assign o_grant_count[n*16 +: 16] = cnt[n];
  end
`endif
endmodule
